// File: rtl/ext_trig_conditioner.sv
// External trigger conditioner: glitch filter, edge pulses, post-rise holdoff and saturating event count.
// Optional timestamp capture of accepted rises is built when EXT_TRIG_TIMESTAMP_EN is defined.
module ext_trig_conditioner #(
    parameter int FILTER_LEN = 4,
    parameter int HOLDOFF    = 100,
    parameter int CNT_WIDTH  = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 SYNC_IN,
    input  logic                 ENABLE,
    input  logic                 CNT_CLEAR,
    output logic                 LEVEL_OUT,
    output logic                 RISE_PULSE,
    output logic                 FALL_PULSE,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] EVENT_COUNT
`ifdef EXT_TRIG_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]  TIMESTAMP,
    output logic                 TS_VALID
`endif
);

    if (FILTER_LEN < 1 || FILTER_LEN > 255 || HOLDOFF < 0 || HOLDOFF > 65535 ||
        CNT_WIDTH < 1 || TS_WIDTH < 1) begin : g_bad_params
        $error("ext_trig_conditioner: parameter out of legal range");
    end

    localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF);

    typedef enum logic {
        ST_IDLE,
        ST_HOLDOFF
    } state_t;

    state_t               state_reg, state_next;
    logic [7:0]           filt_cnt_reg, filt_cnt_next;
    logic [15:0]          hold_cnt_reg, hold_cnt_next;
    logic                 level_reg, level_next;
    logic                 rise_reg, rise_next;
    logic                 fall_reg, fall_next;
    logic                 busy_reg, busy_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 flip;
    logic                 rise_det;
    logic                 fall_det;

    // Mismatch run counter: the level only follows SYNC_IN after FILTER_LEN agreeing samples.
    always_comb begin
        flip          = 1'b0;
        filt_cnt_next = '0;
        if (SYNC_IN != level_reg) begin
            if (filt_cnt_reg == FILT_LAST) begin
                flip = 1'b1;
            end else begin
                filt_cnt_next = filt_cnt_reg + 8'd1;
            end
        end
        level_next = level_reg ^ flip;
    end

    assign rise_det = flip & ~level_reg;
    assign fall_det = flip & level_reg;

    // BUSY is registered from the holdoff state, so it trails RISE_PULSE by one cycle and
    // the state lingers one edge past the last BUSY cycle, rejecting a rise on that edge.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        busy_next     = 1'b0;
        rise_next     = 1'b0;
        fall_next     = 1'b0;
        if (!ENABLE) begin
            state_next    = ST_IDLE;
            hold_cnt_next = '0;
        end else begin
            fall_next = fall_det;
            case (state_reg)
                ST_IDLE: begin
                    if (rise_det) begin
                        rise_next = 1'b1;
                        if (HOLDOFF > 0) begin
                            state_next    = ST_HOLDOFF;
                            hold_cnt_next = '0;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next    = ST_IDLE;
                        hold_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 16'd1;
                        busy_next     = 1'b1;
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    hold_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        count_next = count_reg;
        if (CNT_CLEAR) begin
            count_next = '0;
        end else if (rise_next && (count_reg != '1)) begin
            count_next = count_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg    <= ST_IDLE;
            filt_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            level_reg    <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            filt_cnt_reg <= filt_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            level_reg    <= level_next;
            rise_reg     <= rise_next;
            fall_reg     <= fall_next;
            busy_reg     <= busy_next;
            count_reg    <= count_next;
        end
    end

    assign LEVEL_OUT   = level_reg;
    assign RISE_PULSE  = rise_reg;
    assign FALL_PULSE  = fall_reg;
    assign BUSY        = busy_reg;
    assign EVENT_COUNT = count_reg;

`ifdef EXT_TRIG_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_reg, ts_cnt_next;
    logic [TS_WIDTH-1:0] ts_reg;
    logic                ts_valid_reg;

    assign ts_cnt_next = ts_cnt_reg + TS_WIDTH'(1);

    // Captures the counter value that is visible during the RISE_PULSE cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ts_cnt_reg   <= '0;
            ts_reg       <= '0;
            ts_valid_reg <= 1'b0;
        end else begin
            ts_cnt_reg <= ts_cnt_next;
            if (rise_next) begin
                ts_reg <= ts_cnt_next;
            end
            if (CNT_CLEAR) begin
                ts_valid_reg <= 1'b0;
            end else if (rise_next) begin
                ts_valid_reg <= 1'b1;
            end
        end
    end

    assign TIMESTAMP = ts_reg;
    assign TS_VALID  = ts_valid_reg;
`endif

endmodule

// File: tb/tb_ext_trig_conditioner.sv
// Bench for ext_trig_conditioner: segment table with hand-derived end states plus a per-cycle scoreboard.
module tb_ext_trig_conditioner;
    localparam int FL   = 4;
    localparam int HO   = 10;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    typedef struct packed {
        logic          level;
        logic          rise;
        logic          fall;
        logic          busy;
        logic [CW-1:0] count;
    } obs_t;

    typedef struct {
        logic sync;
        logic en;
        logic clr;
        int   n;
        obs_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync_in = 1'b0;
    logic          enable = 1'b0;
    logic          cnt_clear = 1'b0;
    logic          level_out, rise_pulse, fall_pulse, busy;
    logic [CW-1:0] event_count;
`ifdef EXT_TRIG_TIMESTAMP_EN
    logic [31:0]   timestamp;
    logic          ts_valid;
    logic [32:0]   ts_q[$];
    logic [31:0]   m_ts, m_tstamp;
    logic          m_tsv;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    obs_t sb[$];
    logic m_level;
    int   m_run, m_dead, m_count;
    vec_t tbl[22];

    always #5 clk = ~clk;

    ext_trig_conditioner #(
        .FILTER_LEN(FL),
        .HOLDOFF   (HO),
        .CNT_WIDTH (CW)
    ) dut (
        .CLK        (clk),
        .RESETN     (rst_n),
        .SYNC_IN    (sync_in),
        .ENABLE     (enable),
        .CNT_CLEAR  (cnt_clear),
        .LEVEL_OUT  (level_out),
        .RISE_PULSE (rise_pulse),
        .FALL_PULSE (fall_pulse),
        .BUSY       (busy),
        .EVENT_COUNT(event_count)
`ifdef EXT_TRIG_TIMESTAMP_EN
        ,
        .TIMESTAMP  (timestamp),
        .TS_VALID   (ts_valid)
`endif
    );

    function automatic vec_t mk(input logic s, input logic e, input logic c, input int n,
                                input logic l, input logic r, input logic f, input logic b,
                                input int cnt);
        vec_t v;
        v.sync = s;
        v.en   = e;
        v.clr  = c;
        v.n    = n;
        v.exp  = '{level: l, rise: r, fall: f, busy: b, count: CW'(cnt)};
        return v;
    endfunction

    function automatic obs_t dut_obs();
        obs_t a;
        a = '{level: level_out, rise: rise_pulse, fall: fall_pulse, busy: busy, count: event_count};
        return a;
    endfunction

    // Reference model: rises are rejected for HO+1 edges after an accepted one, BUSY covers the first HO.
    task automatic model_step();
        obs_t e;
        logic flip, rejected;
        e = '0;
        if (!rst_n) begin
            m_level = 1'b0;
            m_run   = 0;
            m_dead  = 0;
            m_count = 0;
`ifdef EXT_TRIG_TIMESTAMP_EN
            m_ts     = '0;
            m_tstamp = '0;
            m_tsv    = 1'b0;
`endif
        end else begin
            flip = 1'b0;
            if (sync_in != m_level) begin
                m_run++;
                if (m_run == FL) begin
                    flip  = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_level = m_level ^ flip;
            e.level = m_level;
            if (enable) begin
                rejected = (m_dead > 0);
                e.busy   = (m_dead > 1);
                if (m_dead > 0) m_dead--;
                e.rise = flip && m_level && !rejected;
                e.fall = flip && !m_level;
                if (e.rise) m_dead = HO + 1;
            end else begin
                m_dead = 0;
            end
            if (cnt_clear) m_count = 0;
            else if (e.rise && m_count != MAXC) m_count++;
            e.count = CW'(m_count);
`ifdef EXT_TRIG_TIMESTAMP_EN
            m_ts = m_ts + 32'd1;
            if (e.rise) m_tstamp = m_ts;
            if (cnt_clear) m_tsv = 1'b0;
            else if (e.rise) m_tsv = 1'b1;
`endif
        end
        sb.push_back(e);
`ifdef EXT_TRIG_TIMESTAMP_EN
        ts_q.push_back({m_tsv, m_tstamp});
`endif
    endtask

    task automatic sb_check();
        obs_t e, a;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        a = dut_obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL sb cycle %0d: got lvl/rise/fall/busy/cnt %b expected %b", cycle, a, e);
        end
`ifdef EXT_TRIG_TIMESTAMP_EN
        begin
            logic [32:0] te;
            te = ts_q.pop_front();
            checks++;
            if ({ts_valid, timestamp} !== te) begin
                errors++;
                $display("FAIL ts cycle %0d: got %h expected %h", cycle, {ts_valid, timestamp}, te);
            end
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cycle++;
        sb_check();
    endtask

    task automatic check_outs(input string name, input obs_t exp);
        obs_t a;
        a = dut_obs();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got lvl/rise/fall/busy/cnt %b required %b", name, a, exp);
        end
    endtask

    task automatic run_seg(input vec_t v, input string name);
        sync_in   = v.sync;
        enable    = v.en;
        cnt_clear = v.clr;
        repeat (v.n) tick();
        check_outs(name, v.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //               sync en clr n   lvl rise fall busy cnt
        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b1, 1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        tbl[16] = mk(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 4);
        tbl[18] = mk(1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        tbl[20] = mk(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        tbl[21] = mk(1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 4);

        repeat (3) tick();
        check_outs("reset_state", '0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            run_seg(tbl[i], $sformatf("table_%0d", i));
        end

        for (int k = 0; k < 12; k++) begin
            run_seg(mk(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, k > 0, (4 + k > MAXC) ? MAXC : 4 + k),
                    $sformatf("sat_fall_%0d", k));
            run_seg(mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, (5 + k > MAXC) ? MAXC : 5 + k),
                    $sformatf("sat_rise_%0d", k));
        end

        run_seg(mk(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b1, MAXC), "clr_fall");
        run_seg(mk(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, MAXC), "clr_pre");
        run_seg(mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0), "clr_with_rise");
        run_seg(mk(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0), "rst_fall");
        run_seg(mk(1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1), "rst_rise");
        run_seg(mk(1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1), "rst_in_holdoff");

        #2 rst_n = 1'b0;
        #1 check_outs("async_reset", '0);
        repeat (2) tick();
        rst_n = 1'b1;
        run_seg(mk(1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0), "post_reset");
        run_seg(mk(1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1), "post_reset_rise");
        run_seg(mk(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 0), "final_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
